truth_table_sweeper: RTL and testbench

- Sequential harness that drives every input vector into a combinational N-input, 1-output logic block (ports x0..x(N-1), y0), one vector at a time.
- Samples y0 for each vector and packs the results into a 2^N-bit truth table.
- Also reports the onset count (number of vectors with y0=1).
- Sits on the stimulus/readback side of the optimized combinational benchmarks, for on-chip equivalence checking against golden truth tables.

---
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake and data bundle between the truth-table sweeper and the harness
// that owns the block under test and consumes the packed result.
interface truth_table_sweeper_if #(
    parameter int N_IN = 6
);
    logic                    start;
    logic                    abort;
    logic                    y_in;
    logic                    tt_ack;
    logic [N_IN-1:0]         x_out;
    logic                    busy;
    logic                    tt_valid;
    logic [(1<<N_IN)-1:0]    tt_out;
    logic [N_IN:0]           onset_count;

    modport master (
        output start, abort, y_in, tt_ack,
        input  x_out, busy, tt_valid, tt_out, onset_count
    );

    modport slave (
        input  start, abort, y_in, tt_ack,
        output x_out, busy, tt_valid, tt_out, onset_count
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N_IN-input combinational block, samples y0
// after SETTLE cycles per vector and packs the answers into a truth table.
module truth_table_sweeper #(
    parameter int N_IN   = 6,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int NVEC = 1 << N_IN;
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    logic [1:0]       state_q,  state_d;
    logic [N_IN-1:0]  idx_q,    idx_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [NVEC-1:0]  tt_q,     tt_d;
    logic [N_IN:0]    onset_q,  onset_d;

    logic             clear_tt;
    logic             capture;

    // abort wins over every transition, including the capture of the current sample
    assign clear_tt = (state_q == S_IDLE)   && bus.start && !bus.abort;
    assign capture  = (state_q == S_SAMPLE) && !bus.abort;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        onset_d = onset_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                    onset_d = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                onset_d = onset_q + (N_IN+1)'(bus.y_in);
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_DONE: begin
                if (bus.tt_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            cnt_d   = cnt_q;
            onset_d = onset_q;
        end
    end

    // One decoder per table bit: only the bit addressed by the current vector moves
    generate
        for (genvar gi = 0; gi < NVEC; gi++) begin : g_tt_bit
            always_comb begin
                tt_d[gi] = tt_q[gi];
                if (clear_tt) begin
                    tt_d[gi] = 1'b0;
                end else if (capture && (idx_q == N_IN'(gi))) begin
                    tt_d[gi] = bus.y_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            onset_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            onset_q <= onset_d;
        end
    end

    // In DONE the index still holds the terminal vector, so x_out keeps its last value
    assign bus.x_out       = (state_q == S_IDLE) ? '0 : idx_q;
    assign bus.busy        = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign bus.tt_valid    = (state_q == S_DONE);
    assign bus.tt_out      = tt_q;
    assign bus.onset_count = onset_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=1, one with SETTLE=3,
// each wired to a selectable combinational function of x_out.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(6)) ifa ();
    truth_table_sweeper_if #(.N_IN(6)) ifb ();

    truth_table_sweeper #(.N_IN(6), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    truth_table_sweeper #(.N_IN(6), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int          errors = 0;
    int          checks = 0;
    int          fsel_a, fsel_b;
    logic [63:0] rmask_a, rmask_b;

    // Function codes: 0 ~x0, 1 AND of all, 2 constant 1, 3 x5, 4 x0^x1, else random mask
    function automatic logic eval(input int sel, input logic [63:0] m, input logic [5:0] x);
        case (sel)
            0:       return ~x[0];
            1:       return &x;
            2:       return 1'b1;
            3:       return x[5];
            4:       return x[0] ^ x[1];
            default: return m[x];
        endcase
    endfunction

    assign ifa.y_in = eval(fsel_a, rmask_a, ifa.x_out);
    assign ifb.y_in = eval(fsel_b, rmask_b, ifb.x_out);

    int          cur;
    logic        c_valid, c_busy;
    logic [5:0]  c_x;
    logic [63:0] c_tt;
    logic [6:0]  c_on;
    always_comb begin
        c_valid = ifa.tt_valid;
        c_busy  = ifa.busy;
        c_x     = ifa.x_out;
        c_tt    = ifa.tt_out;
        c_on    = ifa.onset_count;
        if (cur != 0) begin
            c_valid = ifb.tt_valid;
            c_busy  = ifb.busy;
            c_x     = ifb.x_out;
            c_tt    = ifb.tt_out;
            c_on    = ifb.onset_count;
        end
    end

    typedef struct {
        int          fsel;
        logic [63:0] tt;
        int          onset;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic s, input logic a, input logic k);
        if (inst == 0) begin
            ifa.start = s; ifa.abort = a; ifa.tt_ack = k;
        end else begin
            ifb.start = s; ifb.abort = a; ifb.tt_ack = k;
        end
    endtask

    // Starts a sweep at the current negedge and counts cycles until tt_valid.
    task automatic run_sweep(input int inst, input int inj_start, input int inj_ack,
                             output int lat, output int bcnt, output int xerr);
        int per;
        cur  = inst;
        per  = (inst == 0) ? 2 : 4;
        drive(inst, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        lat = 0; bcnt = 0; xerr = 0;
        while (!c_valid && lat < 3000) begin
            if (c_busy) bcnt++;
            if (c_x !== 6'(lat / per)) xerr++;
            drive(inst, lat == inj_start, 1'b0, lat == inj_ack);
            @(negedge clk);
            lat++;
        end
        drive(inst, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack_done(input int inst, input string name);
        cur = inst;
        drive(inst, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(inst, 1'b0, 1'b0, 1'b0);
        chk({name, "_ack_valid"}, 64'(c_valid), 64'd0);
        chk({name, "_ack_busy"},  64'(c_busy),  64'd0);
    endtask

    task automatic sweep_check(input string name, input int inst, input logic [63:0] exp_tt,
                               input int exp_on, input int inj_start, input int inj_ack);
        int lat, bcnt, xerr, exp_lat;
        exp_lat = (inst == 0) ? 128 : 256;
        run_sweep(inst, inj_start, inj_ack, lat, bcnt, xerr);
        $display("sweep %s inst=%0d tt=0x%016h onset=%0d lat=%0d busy=%0d", name, inst, c_tt, c_on, lat, bcnt);
        chk({name, "_latency"}, 64'(lat),  64'(exp_lat));
        chk({name, "_busy"},    64'(bcnt), 64'(exp_lat));
        chk({name, "_xseq"},    64'(xerr), 64'd0);
        chk({name, "_tt"},      c_tt,      exp_tt);
        chk({name, "_onset"},   64'(c_on), 64'(exp_on));
        chk({name, "_x_done"},  64'(c_x),  64'd63);
    endtask

    initial begin
        fsel_a = 0; fsel_b = 3; rmask_a = '0; rmask_b = '0; cur = 0;
        tbl[0] = '{0, 64'h5555555555555555, 32};
        tbl[1] = '{1, 64'h8000000000000000, 1};
        tbl[2] = '{2, 64'hFFFFFFFFFFFFFFFF, 64};
        tbl[3] = '{3, 64'hFFFFFFFF00000000, 32};
        tbl[4] = '{4, 64'h6666666666666666, 32};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(ifa.busy),        64'd0);
        chk("rst_valid", 64'(ifa.tt_valid),    64'd0);
        chk("rst_x",     64'(ifa.x_out),       64'd0);
        chk("rst_tt",    ifa.tt_out,           64'd0);
        chk("rst_onset", 64'(ifa.onset_count), 64'd0);
        chk("rst_b_x",   64'(ifb.x_out),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            fsel_a = tbl[i].fsel;
            sweep_check($sformatf("tbl%0d", i), 0, tbl[i].tt, tbl[i].onset, -1, -1);
            ack_done(0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_hold_tt", i), ifa.tt_out, tbl[i].tt);
        end

        // Slow-settle instance: 4 cycles per vector, x_out checked every cycle
        fsel_b = 3;
        sweep_check("settle3_x5", 1, 64'hFFFFFFFF00000000, 32, -1, -1);
        ack_done(1, "settle3_x5");

        // start at cycle 40 and tt_ack at cycle 60 mid-sweep are both ignored
        fsel_a = 0;
        sweep_check("ignore", 0, 64'h5555555555555555, 32, 40, 60);
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("done_hold%0d_valid", i), 64'(ifa.tt_valid), 64'd1);
            chk($sformatf("done_hold%0d_tt", i),    ifa.tt_out, 64'h5555555555555555);
        end
        // start together with ack in DONE: start is dropped
        drive(0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ackstart%0d_busy", i),  64'(ifa.busy),     64'd0);
            chk($sformatf("ackstart%0d_valid", i), 64'(ifa.tt_valid), 64'd0);
            @(negedge clk);
        end

        // abort at cycle 50
        fsel_a = 1;
        drive(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (49) @(negedge clk);
        chk("pre_abort_busy", 64'(ifa.busy), 64'd1);
        drive(0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("abort_busy",  64'(ifa.busy),     64'd0);
        chk("abort_valid", 64'(ifa.tt_valid), 64'd0);
        chk("abort_x",     64'(ifa.x_out),    64'd0);
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", 64'(ifa.busy), 64'd0);
        sweep_check("after_abort", 0, 64'h8000000000000000, 1, -1, -1);
        ack_done(0, "after_abort");

        // asynchronous reset between edges at cycle 70
        fsel_a = 2;
        drive(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (69) @(negedge clk);
        chk("pre_rst_busy", 64'(ifa.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  64'(ifa.busy),        64'd0);
        chk("arst_valid", 64'(ifa.tt_valid),    64'd0);
        chk("arst_x",     64'(ifa.x_out),       64'd0);
        chk("arst_tt",    ifa.tt_out,           64'd0);
        chk("arst_onset", 64'(ifa.onset_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fsel_a = 4;
        sweep_check("after_rst", 0, 64'h6666666666666666, 32, -1, -1);
        ack_done(0, "after_rst");

        // random functions: expected table is the function itself, onset its popcount
        for (int k = 0; k < 6; k++) begin
            fsel_a  = 5;
            rmask_a = {$urandom, $urandom};
            sweep_check($sformatf("rnd_a%0d", k), 0, rmask_a, $countones(rmask_a), -1, -1);
            ack_done(0, $sformatf("rnd_a%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            fsel_b  = 5;
            rmask_b = {$urandom, $urandom};
            sweep_check($sformatf("rnd_b%0d", k), 1, rmask_b, $countones(rmask_b), -1, -1);
            ack_done(1, $sformatf("rnd_b%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
